// File: rtl/car_alarm_pkg.sv
// Shared types and constants for the car alarm controller and its timer.
package car_alarm_pkg;

  typedef enum logic [1:0] {
    DISARMED = 2'd0,
    ARMED    = 2'd1,
    ENTRY    = 2'd2,
    ALARM    = 2'd3
  } state_t;

  localparam int unsigned DEFAULT_ENTRY_DELAY  = 16;
  localparam int unsigned DEFAULT_SIREN_CYCLES = 64;
  localparam int unsigned EVENT_CNT_MAX        = 255;

  // Width able to hold max(a, b) without wrapping.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/car_alarm_timer.sv
// Saturating up-counter with runtime terminal value; LIMIT sizes the counter.
module car_alarm_timer
  import car_alarm_pkg::*;
#(
  parameter int unsigned LIMIT = DEFAULT_SIREN_CYCLES,
  localparam int unsigned W    = cnt_width(LIMIT, LIMIT)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         enable,
  input  logic [W-1:0] limit,
  output logic         done
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

  // Asserted for the single cycle in which the terminal count is reached.
  assign done = enable && (count == limit);

endmodule

// File: rtl/car_alarm_controller.sv
// Car alarm: registered lights-on chime plus arm/entry/siren FSM.
// Optional alarm event counter enabled by defining CAR_ALARM_EVENT_CNT_EN.
module car_alarm_controller
  import car_alarm_pkg::*;
#(
  parameter int unsigned NUM_DOORS    = 4,
  parameter int unsigned ENTRY_DELAY  = DEFAULT_ENTRY_DELAY,
  parameter int unsigned SIREN_CYCLES = DEFAULT_SIREN_CYCLES
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_DOORS-1:0] OpenDoorSign,
  input  logic                 CarLightsOnSign,
  input  logic                 IgnitionSignalOn,
  input  logic                 ArmReq,
  input  logic                 DisarmReq,
  output logic                 CarAlarmSignal,
  output logic                 Armed,
  output logic                 SirenOn,
  output logic [NUM_DOORS-1:0] TriggerDoor
`ifdef CAR_ALARM_EVENT_CNT_EN
  ,
  output logic [7:0]           AlarmEventCount
`endif
);

  localparam int unsigned TMAX = (ENTRY_DELAY > SIREN_CYCLES) ? ENTRY_DELAY : SIREN_CYCLES;
  localparam int unsigned CW   = cnt_width(ENTRY_DELAY, SIREN_CYCLES);

  state_t               state, next;
  logic [NUM_DOORS-1:0] door_prev;
  logic [NUM_DOORS-1:0] door_rise;
  logic [NUM_DOORS-1:0] trig_next;
  logic                 timer_clear;
  logic                 timer_en;
  logic                 timer_done;
  logic [CW-1:0]        limit_sel;

  assign door_rise = OpenDoorSign & ~door_prev;

  // Timer controls depend only on the current state, so next-state logic can use done freely.
  assign timer_en  = (state == ENTRY) || (state == ALARM);
  assign limit_sel = (state == ALARM) ? CW'(SIREN_CYCLES - 1) : CW'(ENTRY_DELAY - 1);

  car_alarm_timer #(
    .LIMIT (TMAX)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (timer_clear),
    .enable (timer_en),
    .limit  (limit_sel),
    .done   (timer_done)
  );

  always_comb begin
    next      = state;
    trig_next = TriggerDoor;
    case (state)
      DISARMED: begin
        if (ArmReq && !DisarmReq && !(|OpenDoorSign) && !IgnitionSignalOn) begin
          next = ARMED;
        end
      end
      ARMED: begin
        if (DisarmReq) begin
          next = DISARMED;
        end else if (IgnitionSignalOn) begin
          next      = ALARM;
          trig_next = '0;
        end else if (|door_rise) begin
          next      = ENTRY;
          trig_next = door_rise;
        end
      end
      ENTRY: begin
        trig_next = TriggerDoor | door_rise;
        if (DisarmReq) begin
          next = DISARMED;
        end else if (timer_done) begin
          next = ALARM;
        end
      end
      ALARM: begin
        if (DisarmReq) begin
          next = DISARMED;
        end else if (timer_done) begin
          next = ARMED;
        end
      end
      default: next = DISARMED;
    endcase
    if (next == DISARMED) begin
      trig_next = '0;
    end
    timer_clear = (next != state);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= DISARMED;
      door_prev      <= '0;
      TriggerDoor    <= '0;
      CarAlarmSignal <= 1'b0;
      Armed          <= 1'b0;
      SirenOn        <= 1'b0;
    end else begin
      state          <= next;
      door_prev      <= OpenDoorSign;
      TriggerDoor    <= trig_next;
      CarAlarmSignal <= CarLightsOnSign & (|OpenDoorSign) & ~IgnitionSignalOn;
      Armed          <= (next != DISARMED);
      SirenOn        <= (next == ALARM);
    end
  end

`ifdef CAR_ALARM_EVENT_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      AlarmEventCount <= '0;
    end else if ((next == ALARM) && (state != ALARM) && (AlarmEventCount != 8'(EVENT_CNT_MAX))) begin
      AlarmEventCount <= AlarmEventCount + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_car_alarm_controller.sv
// Scoreboard-driven bench for car_alarm_controller (default 4 doors, 16/64 timing).
module tb_car_alarm_controller;

  localparam int ND = 4;
  localparam int ED = 16;
  localparam int SC = 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [ND-1:0] door = '0;
  logic          lights = 1'b0;
  logic          ign = 1'b0;
  logic          arm = 1'b0;
  logic          disarm = 1'b0;
  logic          chime, armed, siren;
  logic [ND-1:0] trig;
`ifdef CAR_ALARM_EVENT_CNT_EN
  logic [7:0]    evcnt;
`endif

  typedef struct {
    string      name;
    logic [7:0] v;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int unsigned total = 0;
  int unsigned passed = 0;

  car_alarm_controller #(
    .NUM_DOORS    (ND),
    .ENTRY_DELAY  (ED),
    .SIREN_CYCLES (SC)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .OpenDoorSign     (door),
    .CarLightsOnSign  (lights),
    .IgnitionSignalOn (ign),
    .ArmReq           (arm),
    .DisarmReq        (disarm),
    .CarAlarmSignal   (chime),
    .Armed            (armed),
    .SirenOn          (siren),
    .TriggerDoor      (trig)
`ifdef CAR_ALARM_EVENT_CNT_EN
    ,
    .AlarmEventCount  (evcnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] obs();
    return {1'b0, chime, armed, siren, trig};
  endfunction

  function automatic logic [7:0] mk(input logic c, input logic a, input logic s, input logic [ND-1:0] t);
    return {1'b0, c, a, s, t};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    sb.push_back('{"reset_hold", mk(1'b0, 1'b0, 1'b0, 4'b0000)});
    step();
    step();
    e = sb.pop_front(); total++;
    if (obs() !== e.v) $display("FAIL %s got %b expected %b", e.name, obs(), e.v); else passed++;
    rst_n = 1'b1;
    sb.push_back('{"reset_release", mk(1'b0, 1'b0, 1'b0, 4'b0000)});
    step();
    e = sb.pop_front(); total++;
    if (obs() !== e.v) $display("FAIL %s got %b expected %b", e.name, obs(), e.v); else passed++;
  endtask

  task automatic test_chime();
    lights = 1'b1; door = 4'b0100; ign = 1'b0;
    sb.push_back('{"chime_on", mk(1'b1, 1'b0, 1'b0, 4'b0000)});
    step();
    e = sb.pop_front(); total++;
    if (obs() !== e.v) $display("FAIL %s got %b expected %b", e.name, obs(), e.v); else passed++;
    ign = 1'b1;
    sb.push_back('{"chime_ign_off", mk(1'b0, 1'b0, 1'b0, 4'b0000)});
    step();
    e = sb.pop_front(); total++;
    if (obs() !== e.v) $display("FAIL %s got %b expected %b", e.name, obs(), e.v); else passed++;
    ign = 1'b0; door = 4'b0000;
    sb.push_back('{"chime_doors_closed", mk(1'b0, 1'b0, 1'b0, 4'b0000)});
    step();
    e = sb.pop_front(); total++;
    if (obs() !== e.v) $display("FAIL %s got %b expected %b", e.name, obs(), e.v); else passed++;
    lights = 1'b0;
    step();
  endtask

  task automatic test_arm();
    door = 4'b0001; arm = 1'b1;
    sb.push_back('{"arm_door_open", mk(1'b0, 1'b0, 1'b0, 4'b0000)});
    step();
    arm = 1'b0;
    e = sb.pop_front(); total++;
    if (obs() !== e.v) $display("FAIL %s got %b expected %b", e.name, obs(), e.v); else passed++;
    sb.push_back('{"arm_ignored_hold", mk(1'b0, 1'b0, 1'b0, 4'b0000)});
    step();
    e = sb.pop_front(); total++;
    if (obs() !== e.v) $display("FAIL %s got %b expected %b", e.name, obs(), e.v); else passed++;
    door = 4'b0000;
    step();
    arm = 1'b1;
    sb.push_back('{"arm_ok", mk(1'b0, 1'b1, 1'b0, 4'b0000)});
    step();
    arm = 1'b0;
    e = sb.pop_front(); total++;
    if (obs() !== e.v) $display("FAIL %s got %b expected %b", e.name, obs(), e.v); else passed++;
  endtask

  task automatic test_entry_siren();
    logic [ND-1:0] t_exp;
    logic          s_exp;
    door = 4'b1000;
    sb.push_back('{"entry_start", mk(1'b0, 1'b1, 1'b0, 4'b1000)});
    step();
    e = sb.pop_front(); total++;
    if (obs() !== e.v) $display("FAIL %s got %b expected %b", e.name, obs(), e.v); else passed++;
    // Door 0 opens mid-entry and must be ORed into the captured mask.
    for (int k = 1; k <= ED + SC + 3; k++) begin
      if (k == 5) door = 4'b1001;
      t_exp = (k >= 5) ? 4'b1001 : 4'b1000;
      s_exp = (k >= ED) && (k < ED + SC);
      sb.push_back('{$sformatf("entry_k%0d", k), mk(1'b0, 1'b1, s_exp, t_exp)});
      step();
      e = sb.pop_front(); total++;
      if (obs() !== e.v) $display("FAIL %s got %b expected %b", e.name, obs(), e.v); else passed++;
    end
    door = 4'b0000;
    sb.push_back('{"entry_rearmed_close", mk(1'b0, 1'b1, 1'b0, 4'b1001)});
    step();
    e = sb.pop_front(); total++;
    if (obs() !== e.v) $display("FAIL %s got %b expected %b", e.name, obs(), e.v); else passed++;
  endtask

  task automatic test_disarm_in_entry();
    door = 4'b0010;
    sb.push_back('{"dis_entry_start", mk(1'b0, 1'b1, 1'b0, 4'b0010)});
    step();
    e = sb.pop_front(); total++;
    if (obs() !== e.v) $display("FAIL %s got %b expected %b", e.name, obs(), e.v); else passed++;
    for (int k = 1; k <= 9; k++) begin
      sb.push_back('{$sformatf("dis_entry_k%0d", k), mk(1'b0, 1'b1, 1'b0, 4'b0010)});
      step();
      e = sb.pop_front(); total++;
      if (obs() !== e.v) $display("FAIL %s got %b expected %b", e.name, obs(), e.v); else passed++;
    end
    disarm = 1'b1;
    sb.push_back('{"dis_entry_disarm", mk(1'b0, 1'b0, 1'b0, 4'b0000)});
    step();
    disarm = 1'b0;
    e = sb.pop_front(); total++;
    if (obs() !== e.v) $display("FAIL %s got %b expected %b", e.name, obs(), e.v); else passed++;
    for (int k = 0; k < 20; k++) begin
      sb.push_back('{$sformatf("dis_quiet_%0d", k), mk(1'b0, 1'b0, 1'b0, 4'b0000)});
      step();
      e = sb.pop_front(); total++;
      if (obs() !== e.v) $display("FAIL %s got %b expected %b", e.name, obs(), e.v); else passed++;
    end
    door = 4'b0000;
    step();
  endtask

  task automatic test_ignition_and_both_req();
    arm = 1'b1;
    sb.push_back('{"ign_arm", mk(1'b0, 1'b1, 1'b0, 4'b0000)});
    step();
    arm = 1'b0;
    e = sb.pop_front(); total++;
    if (obs() !== e.v) $display("FAIL %s got %b expected %b", e.name, obs(), e.v); else passed++;
    ign = 1'b1;
    sb.push_back('{"ign_trip", mk(1'b0, 1'b1, 1'b1, 4'b0000)});
    step();
    e = sb.pop_front(); total++;
    if (obs() !== e.v) $display("FAIL %s got %b expected %b", e.name, obs(), e.v); else passed++;
    arm = 1'b1; disarm = 1'b1;
    sb.push_back('{"both_req_alarm", mk(1'b0, 1'b0, 1'b0, 4'b0000)});
    step();
    e = sb.pop_front(); total++;
    if (obs() !== e.v) $display("FAIL %s got %b expected %b", e.name, obs(), e.v); else passed++;
    ign = 1'b0;
    sb.push_back('{"both_req_disarmed", mk(1'b0, 1'b0, 1'b0, 4'b0000)});
    step();
    arm = 1'b0; disarm = 1'b0;
    e = sb.pop_front(); total++;
    if (obs() !== e.v) $display("FAIL %s got %b expected %b", e.name, obs(), e.v); else passed++;
  endtask

  task automatic test_reset_mid_alarm();
    arm = 1'b1;
    step();
    arm = 1'b0; ign = 1'b1;
    step();
    lights = 1'b1; door = 4'b0100; ign = 1'b0;
    sb.push_back('{"mid_alarm_active", mk(1'b1, 1'b1, 1'b1, 4'b0000)});
    step();
    e = sb.pop_front(); total++;
    if (obs() !== e.v) $display("FAIL %s got %b expected %b", e.name, obs(), e.v); else passed++;
    #2;
    rst_n = 1'b0;
    sb.push_back('{"async_reset", mk(1'b0, 1'b0, 1'b0, 4'b0000)});
    #1;
    e = sb.pop_front(); total++;
    if (obs() !== e.v) $display("FAIL %s got %b expected %b", e.name, obs(), e.v); else passed++;
    sb.push_back('{"reset_held_edge", mk(1'b0, 1'b0, 1'b0, 4'b0000)});
    step();
    e = sb.pop_front(); total++;
    if (obs() !== e.v) $display("FAIL %s got %b expected %b", e.name, obs(), e.v); else passed++;
    lights = 1'b0; door = 4'b0000;
    rst_n = 1'b1;
    step();
  endtask

`ifdef CAR_ALARM_EVENT_CNT_EN
  task automatic test_event_count();
    int unsigned n;
    sb.push_back('{"evcnt_start", 8'd0});
    e = sb.pop_front(); total++;
    if (evcnt !== e.v) $display("FAIL %s got %0d expected %0d", e.name, evcnt, e.v); else passed++;
    for (int i = 1; i <= 257; i++) begin
      arm = 1'b1;
      step();
      arm = 1'b0; ign = 1'b1;
      step();
      ign = 1'b0; disarm = 1'b1;
      step();
      disarm = 1'b0;
      n = (i > 255) ? 255 : i;
      if (i == 1 || i == 128 || i == 255 || i == 256 || i == 257) begin
        sb.push_back('{$sformatf("evcnt_%0d", i), 8'(n)});
        e = sb.pop_front(); total++;
        if (evcnt !== e.v) $display("FAIL %s got %0d expected %0d", e.name, evcnt, e.v); else passed++;
      end
    end
  endtask
`endif

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_chime();
    test_arm();
    test_entry_siren();
    test_disarm_in_entry();
    test_ignition_and_both_req();
    test_reset_mid_alarm();
`ifdef CAR_ALARM_EVENT_CNT_EN
    test_event_count();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
